// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared types and helpers for the systolic matrix-vector engine:
//             controller state encoding, pipeline latency and counter sizing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        LOAD   = 3'd1,
        READY  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    // Accept-to-result latency for an n x n array. This is a function
    // rather than a bare localparam because the array size is a module
    // parameter.
    function automatic int latency(input int n);
        return 2 * n;
    endfunction

    // Bits needed to count 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/systolic_mm_stream_pe.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pe
//  Purpose  : One weight-stationary processing element. Holds a weight,
//             forwards the activation to the right and accumulates
//             psum_in + act*wgt into a registered partial sum passed down.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             wgt_load, wgt_in       - weight register write
//             act_in / act_out       - activation in, registered pass-right
//             psum_in, psum_valid_in - partial sum and valid from above
//             psum_out, psum_valid_out - registered partial sum and valid
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter bit SIGNED       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wgt_load,
    input  logic [WGT_WIDTH-1:0]    wgt_in,
    input  logic [ACT_WIDTH-1:0]    act_in,
    output logic [ACT_WIDTH-1:0]    act_out,
    input  logic [PE_OUT_WIDTH-1:0] psum_in,
    input  logic                    psum_valid_in,
    output logic [PE_OUT_WIDTH-1:0] psum_out,
    output logic                    psum_valid_out
);

    logic [WGT_WIDTH-1:0]    r_wgt;
    logic [PE_OUT_WIDTH-1:0] w_act_x;
    logic [PE_OUT_WIDTH-1:0] w_wgt_x;

    // Both operands are extended to the result width. The low PE_OUT_WIDTH
    // bits of the product are then exact for either signedness, and the
    // accumulate wraps naturally.
    assign w_act_x = {{(PE_OUT_WIDTH-ACT_WIDTH){SIGNED & act_in[ACT_WIDTH-1]}}, act_in};
    assign w_wgt_x = {{(PE_OUT_WIDTH-WGT_WIDTH){SIGNED & r_wgt[WGT_WIDTH-1]}}, r_wgt};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wgt          <= '0;
            act_out        <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else begin
            if (wgt_load) begin
                r_wgt <= wgt_in;
            end
            act_out        <= act_in;
            psum_out       <= psum_in + w_act_x * w_wgt_x;
            psum_valid_out <= psum_valid_in;
        end
    end

endmodule : systolic_pe
`default_nettype wire

// File: rtl/systolic_mm_stream.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_mm_stream
//  Purpose  : ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic engine
//             computing y_j = sum_k a_k * W[k][j] for streamed vectors.
//  Ports    : clk, reset                        - clock, sync active-high reset
//             wgt_valid/wgt_ready/wgt_row_in    - weight row load handshake
//             act_valid/act_ready/act_data_in,
//             act_last                          - activation stream handshake
//             result_valid/result_data_out,
//             result_last                       - results, 2*ARRAY_SIZE cycles
//                                                 after each accepted beat
//             busy                              - high in LOAD/STREAM/DRAIN
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_mm_stream
    import systolic_pkg::*;
#(
    parameter int ACT_WIDTH    = 8,
    parameter int WGT_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter int ARRAY_SIZE   = 4,
    parameter bit SIGNED       = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wgt_valid,
    output logic                               wgt_ready,
    input  logic [WGT_WIDTH*ARRAY_SIZE-1:0]    wgt_row_in,
    input  logic                               act_valid,
    output logic                               act_ready,
    input  logic [ACT_WIDTH*ARRAY_SIZE-1:0]    act_data_in,
    input  logic                               act_last,
    output logic                               result_valid,
    output logic [PE_OUT_WIDTH*ARRAY_SIZE-1:0] result_data_out,
    output logic                               result_last,
    output logic                               busy
);

    localparam int N       = ARRAY_SIZE;
    localparam int LATENCY = latency(ARRAY_SIZE);
    localparam int CNT_W   = clog2(LATENCY);
    localparam int ROW_W   = clog2(ARRAY_SIZE);

    state_t               r_state;
    logic [ROW_W-1:0]     r_row_cnt;
    logic [CNT_W-1:0]     r_drain_cnt;
    logic [ROW_W-1:0]     w_load_row;
    logic                 w_wgt_fire;
    logic                 w_act_fire;
    logic [N-1:0]         r_v_top;
    logic [LATENCY-1:0]   r_last_pipe;

    logic [ACT_WIDTH-1:0]    w_act        [N][N];
    logic [ACT_WIDTH-1:0]    w_act_unused [N];
    logic [PE_OUT_WIDTH-1:0] w_psum       [N+1][N];
    logic                    w_pv         [N+1][N];
    logic [PE_OUT_WIDTH-1:0] w_dsk_data   [N];
    logic [N-1:0]            w_dsk_valid;
    logic [PE_OUT_WIDTH*N-1:0] w_result_flat;

    assign w_wgt_fire = wgt_valid & wgt_ready;
    assign w_act_fire = act_valid & act_ready;
    // Row 0 is written from EMPTY and READY; LOAD walks the counter.
    assign w_load_row = (r_state == LOAD) ? r_row_cnt : '0;

    always_comb begin
        wgt_ready = 1'b0;
        act_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            EMPTY:  wgt_ready = 1'b1;
            LOAD: begin
                wgt_ready = 1'b1;
                busy      = 1'b1;
            end
            READY: begin
                act_ready = 1'b1;
                wgt_ready = ~act_valid;   // activation wins a tie
            end
            STREAM: begin
                act_ready = 1'b1;
                busy      = 1'b1;
            end
            DRAIN:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_wgt_fire) begin
                    r_state   <= LOAD;
                    r_row_cnt <= ROW_W'(1);
                end
                LOAD: if (w_wgt_fire) begin
                    if (r_row_cnt == ROW_W'(N-1)) begin
                        r_state   <= READY;
                        r_row_cnt <= '0;
                    end else begin
                        r_row_cnt <= r_row_cnt + ROW_W'(1);
                    end
                end
                READY: begin
                    if (w_act_fire) begin
                        r_state     <= act_last ? DRAIN : STREAM;
                        r_drain_cnt <= '0;
                    end else if (w_wgt_fire) begin
                        r_state   <= LOAD;
                        r_row_cnt <= ROW_W'(1);
                    end
                end
                STREAM: if (w_act_fire && act_last) begin
                    r_state     <= DRAIN;
                    r_drain_cnt <= '0;
                end
                DRAIN: begin
                    // Leaves on the same edge that registers result_last.
                    if (r_drain_cnt == CNT_W'(LATENCY-1)) begin
                        r_state     <= READY;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Valid travels along the top row one column per cycle; the last tag
    // rides a plain delay line matching the full pipeline depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_top     <= '0;
            r_last_pipe <= '0;
        end else begin
            r_v_top     <= {r_v_top[N-2:0], w_act_fire};
            r_last_pipe <= {r_last_pipe[LATENCY-2:0], w_act_fire & act_last};
        end
    end

    // Input skew: row k sees its element k cycles after row 0. Bubbles
    // load zeros so idle slots carry no stale operands.
    for (genvar k = 0; k < N; k++) begin : g_skew
        logic [ACT_WIDTH-1:0] r_stage [k+1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= k; s++) begin
                    r_stage[s] <= '0;
                end
            end else begin
                r_stage[0] <= w_act_fire ? act_data_in[k*ACT_WIDTH +: ACT_WIDTH] : '0;
                for (int s = 1; s <= k; s++) begin
                    r_stage[s] <= r_stage[s-1];
                end
            end
        end
        assign w_act[k][0] = r_stage[k];
    end

    for (genvar j = 0; j < N; j++) begin : g_top
        assign w_psum[0][j] = '0;
        assign w_pv[0][j]   = r_v_top[j];
    end

    for (genvar k = 0; k < N; k++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j < N-1) begin : g_mid
                systolic_pe #(
                    .ACT_WIDTH(ACT_WIDTH), .WGT_WIDTH(WGT_WIDTH),
                    .PE_OUT_WIDTH(PE_OUT_WIDTH), .SIGNED(SIGNED)
                ) u_pe (
                    .clk(clk), .reset(reset),
                    .wgt_load(w_wgt_fire && (w_load_row == ROW_W'(k))),
                    .wgt_in(wgt_row_in[j*WGT_WIDTH +: WGT_WIDTH]),
                    .act_in(w_act[k][j]), .act_out(w_act[k][j+1]),
                    .psum_in(w_psum[k][j]), .psum_valid_in(w_pv[k][j]),
                    .psum_out(w_psum[k+1][j]), .psum_valid_out(w_pv[k+1][j])
                );
            end else begin : g_last
                systolic_pe #(
                    .ACT_WIDTH(ACT_WIDTH), .WGT_WIDTH(WGT_WIDTH),
                    .PE_OUT_WIDTH(PE_OUT_WIDTH), .SIGNED(SIGNED)
                ) u_pe (
                    .clk(clk), .reset(reset),
                    .wgt_load(w_wgt_fire && (w_load_row == ROW_W'(k))),
                    .wgt_in(wgt_row_in[j*WGT_WIDTH +: WGT_WIDTH]),
                    .act_in(w_act[k][j]), .act_out(w_act_unused[k]),
                    .psum_in(w_psum[k][j]), .psum_valid_in(w_pv[k][j]),
                    .psum_out(w_psum[k+1][j]), .psum_valid_out(w_pv[k+1][j])
                );
            end
        end
    end

    // De-skew: column j finishes j cycles after column 0, so it is delayed
    // N-1-j cycles to realign every column before the output register.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_direct
            assign w_dsk_data[j]  = w_psum[N][j];
            assign w_dsk_valid[j] = w_pv[N][j];
        end else begin : g_delay
            logic [PE_OUT_WIDTH-1:0] r_d [D];
            logic                    r_v [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < D; s++) begin
                        r_d[s] <= '0;
                        r_v[s] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= w_psum[N][j];
                    r_v[0] <= w_pv[N][j];
                    for (int s = 1; s < D; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign w_dsk_data[j]  = r_d[D-1];
            assign w_dsk_valid[j] = r_v[D-1];
        end
    end

    always_comb begin
        w_result_flat = '0;
        for (int j = 0; j < N; j++) begin
            w_result_flat[j*PE_OUT_WIDTH +: PE_OUT_WIDTH] = w_dsk_data[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid    <= 1'b0;
            result_last     <= 1'b0;
            result_data_out <= '0;
        end else begin
            result_valid <= &w_dsk_valid;
            result_last  <= (&w_dsk_valid) & r_last_pipe[LATENCY-1];
            if (&w_dsk_valid) begin
                result_data_out <= w_result_flat;
            end
        end
    end

endmodule : systolic_mm_stream
`default_nettype wire

// File: tb/tb_systolic_mm_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_mm_stream
//  Purpose  : Self-checking bench for systolic_mm_stream. A 2x2 unsigned and
//             a 4x4 signed instance are driven with directed vectors; every
//             accepted beat queues its hand-computed result and due cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_stream;

    typedef struct packed {
        logic         valid;
        logic [31:0]  a;
        logic         last;
        logic [127:0] y;
    } vec_t;

    typedef struct packed {
        int           due;
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncnt  = 0;

    // 2x2 unsigned instance
    logic        rst2 = 1'b1, wv2 = 1'b0, av2 = 1'b0, al2 = 1'b0;
    logic [15:0] wrow2 = '0, ad2 = '0;
    logic        wr2, ar2, rv2, rl2, busy2;
    logic [63:0] rd2;
    logic [127:0] cur_exp2 = '0;
    exp_t q2[$];

    // 4x4 signed instance
    logic         rst4 = 1'b1, wv4 = 1'b0, av4 = 1'b0, al4 = 1'b0;
    logic [31:0]  wrow4 = '0, ad4 = '0;
    logic         wr4, ar4, rv4, rl4, busy4;
    logic [127:0] rd4;
    logic [127:0] cur_exp4 = '0;
    exp_t q4[$];

    vec_t vecs[9];

    systolic_mm_stream #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(32),
                         .ARRAY_SIZE(2), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .reset(rst2),
        .wgt_valid(wv2), .wgt_ready(wr2), .wgt_row_in(wrow2),
        .act_valid(av2), .act_ready(ar2), .act_data_in(ad2), .act_last(al2),
        .result_valid(rv2), .result_data_out(rd2), .result_last(rl2),
        .busy(busy2)
    );

    systolic_mm_stream #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PE_OUT_WIDTH(32),
                         .ARRAY_SIZE(4), .SIGNED(1'b1)) u_dut4 (
        .clk(clk), .reset(rst4),
        .wgt_valid(wv4), .wgt_ready(wr4), .wgt_row_in(wrow4),
        .act_valid(av4), .act_ready(ar4), .act_data_in(ad4), .act_last(al4),
        .result_valid(rv4), .result_data_out(rd4), .result_last(rl4),
        .busy(busy4)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Scoreboard: results must appear at the negedge 2N+1 after the negedge
    // at which the accepting handshake was seen (2N edges after the accept).
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (rv2) begin
            if (q2.size() == 0) fail("dut2 unexpected result_valid");
            else begin
                e = q2.pop_front();
                chk("dut2 latency", 128'(ncnt), 128'(e.due));
                chk("dut2 data", {64'd0, rd2}, e.data);
                chk("dut2 last", {127'd0, rl2}, {127'd0, e.last});
            end
        end
        if (q2.size() > 0 && q2[0].due < ncnt) begin
            fail("dut2 missing result");
            void'(q2.pop_front());
        end
        if (av2 && ar2 && !rst2) q2.push_back('{due: ncnt + 5, data: cur_exp2, last: al2});

        if (rv4) begin
            if (q4.size() == 0) fail("dut4 unexpected result_valid");
            else begin
                e = q4.pop_front();
                chk("dut4 latency", 128'(ncnt), 128'(e.due));
                chk("dut4 data", rd4, e.data);
                chk("dut4 last", {127'd0, rl4}, {127'd0, e.last});
            end
        end
        if (q4.size() > 0 && q4[0].due < ncnt) begin
            fail("dut4 missing result");
            void'(q4.pop_front());
        end
        if (av4 && ar4 && !rst4) q4.push_back('{due: ncnt + 9, data: cur_exp4, last: al4});
    end

    task automatic load2(input logic [15:0] r0, input logic [15:0] r1);
        for (int k = 0; k < 2; k++) begin
            int g = 0;
            wv2 = 1'b1;
            wrow2 = (k == 0) ? r0 : r1;
            @(negedge clk);
            while (!wr2 && g < 50) begin @(negedge clk); g++; end
            if (!wr2) fail("dut2 wgt_ready timeout");
            @(posedge clk); #1;
        end
        wv2 = 1'b0;
    endtask

    task automatic load4(input logic [127:0] rows);
        for (int k = 0; k < 4; k++) begin
            int g = 0;
            wv4 = 1'b1;
            wrow4 = rows[k*32 +: 32];
            @(negedge clk);
            while (!wr4 && g < 50) begin @(negedge clk); g++; end
            if (!wr4) fail("dut4 wgt_ready timeout");
            @(posedge clk); #1;
        end
        wv4 = 1'b0;
    endtask

    task automatic beat2(input logic [15:0] a, input logic last, input logic [127:0] y);
        int g = 0;
        av2 = 1'b1; ad2 = a; al2 = last; cur_exp2 = y;
        @(negedge clk);
        while (!ar2 && g < 50) begin @(negedge clk); g++; end
        if (!ar2) fail("dut2 act_ready timeout");
        @(posedge clk); #1;
        av2 = 1'b0; al2 = 1'b0;
    endtask

    task automatic beat4(input vec_t v);
        int g = 0;
        av4 = v.valid; ad4 = v.a; al4 = v.last; cur_exp4 = v.y;
        @(negedge clk);
        if (v.valid) begin
            while (!ar4 && g < 50) begin @(negedge clk); g++; end
            if (!ar4) fail("dut4 act_ready timeout");
        end
        @(posedge clk); #1;
        av4 = 1'b0; al4 = 1'b0;
    endtask

    task automatic drain(input int which);
        int g = 0;
        while (((which == 2) ? q2.size() : q4.size()) != 0 && g < 100) begin
            @(negedge clk); g++;
        end
        if (g >= 100) fail("drain timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] W_IDENT = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    localparam logic [127:0] W_TWOI  = {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002};
    localparam logic [127:0] W_80    = {4{32'h80808080}};

    initial begin
        //            valid  a              last  y
        vecs[0] = '{1'b1, 32'h05807FFF, 1'b1, {32'd5, 32'hFFFFFF80, 32'd127, 32'hFFFFFFFF}};
        vecs[1] = '{1'b1, 32'h80808080, 1'b1, {4{32'h00010000}}};
        vecs[2] = '{1'b1, 32'h04030201, 1'b1, {32'd8, 32'd6, 32'd4, 32'd2}};
        vecs[3] = '{1'b1, 32'h04030201, 1'b0, {32'd8, 32'd6, 32'd4, 32'd2}};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 128'd0};
        vecs[5] = '{1'b1, 32'h08070605, 1'b0, {32'd16, 32'd14, 32'd12, 32'd10}};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 128'd0};
        vecs[7] = '{1'b1, 32'hFCFDFEFF, 1'b0, {32'hFFFFFFF8, 32'hFFFFFFFA, 32'hFFFFFFFC, 32'hFFFFFFFE}};
        vecs[8] = '{1'b1, 32'h281E140A, 1'b1, {32'd80, 32'd60, 32'd40, 32'd20}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset result_valid", {126'd0, rv2, rv4}, 128'd0);
        chk("reset result_last", {126'd0, rl2, rl4}, 128'd0);
        chk("reset result_data", rd4 | {64'd0, rd2}, 128'd0);
        chk("reset busy", {126'd0, busy2, busy4}, 128'd0);
        chk("reset wgt_ready", {126'd0, wr2, wr4}, 128'd3);
        chk("reset act_ready", {126'd0, ar2, ar4}, 128'd0);
        @(posedge clk); #1;
        rst2 = 1'b0; rst4 = 1'b0;

        // 2x2 unsigned basic batch
        load2(16'h0201, 16'h0403);
        @(negedge clk);
        chk("dut2 ready after load act_ready", {127'd0, ar2}, 128'd1);
        chk("dut2 ready after load busy", {127'd0, busy2}, 128'd0);
        @(posedge clk); #1;
        beat2(16'h0201, 1'b0, {64'd0, 32'd10, 32'd7});
        beat2(16'h0403, 1'b1, {64'd0, 32'd22, 32'd15});
        @(negedge clk);
        chk("dut2 drain act_ready", {127'd0, ar2}, 128'd0);
        chk("dut2 drain busy", {127'd0, busy2}, 128'd1);
        drain(2);
        @(negedge clk);
        chk("dut2 back to ready act_ready", {127'd0, ar2}, 128'd1);
        chk("dut2 back to ready busy", {127'd0, busy2}, 128'd0);
        @(posedge clk); #1;

        // Priority: weight and activation offered together in READY
        wv2 = 1'b1; wrow2 = 16'h0909;
        av2 = 1'b1; ad2 = 16'h0201; al2 = 1'b0; cur_exp2 = {64'd0, 32'd10, 32'd7};
        @(negedge clk);
        chk("dut2 priority wgt_ready", {127'd0, wr2}, 128'd0);
        chk("dut2 priority act_ready", {127'd0, ar2}, 128'd1);
        @(posedge clk); #1;
        ad2 = 16'h0403; al2 = 1'b1; cur_exp2 = {64'd0, 32'd22, 32'd15};
        @(negedge clk);
        chk("dut2 stream wgt_ready", {127'd0, wr2}, 128'd0);
        @(posedge clk); #1;
        av2 = 1'b0; al2 = 1'b0; wv2 = 1'b0;
        drain(2);

        // 4x4 signed: identity, single-beat batch from READY
        load4(W_IDENT);
        beat4(vecs[0]);
        @(negedge clk);
        chk("dut4 single beat drain busy", {127'd0, busy4}, 128'd1);
        drain(4);
        // Most negative operands everywhere
        load4(W_80);
        beat4(vecs[1]);
        drain(4);
        // Reload with 2*I must fully replace the 0x80 weights
        load4(W_TWOI);
        beat4(vecs[2]);
        drain(4);
        // Bubbles on slots 2 and 4
        for (int i = 3; i < 9; i++) beat4(vecs[i]);
        drain(4);

        // Reset two cycles after the third accept of an open batch
        beat4(vecs[3]);
        beat4(vecs[5]);
        beat4(vecs[7]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        q4.delete();
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(negedge clk);
        chk("dut4 post-reset wgt_ready", {127'd0, wr4}, 128'd1);
        chk("dut4 post-reset act_ready", {127'd0, ar4}, 128'd0);
        chk("dut4 post-reset busy", {127'd0, busy4}, 128'd0);
        for (int i = 0; i < 16; i++) begin
            chk("dut4 flushed result_valid", {127'd0, rv4}, 128'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        load4(W_TWOI);
        beat4(vecs[2]);
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_systolic_mm_stream
`default_nettype wire

// File: doc/systolic_mm_stream.md
Name: systolic_mm_stream

Overview:
- Weight-stationary ARRAY_SIZE x ARRAY_SIZE systolic matrix-vector engine.
- Generalises the fixed 2x2 array with:
  - valid/ready weight loading and activation streaming;
  - internal input skew and output de-skew;
  - signed/unsigned mode and last-beat tagging.
- Sits between the activation/weight buffers and the output accumulator path of the accelerator datapath.

Parameters:
ACT_WIDTH, 8, activation element width
WGT_WIDTH, 8, weight element width
PE_OUT_WIDTH, 32, partial-sum/result element width (must be >= ACT_WIDTH+WGT_WIDTH)
ARRAY_SIZE, 4, array rows = columns = vector length (>= 2)
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wgt_valid  input  1  weight row beat valid
wgt_ready  output  1  weight row beat accepted when valid&ready
wgt_row_in  input  WGT_WIDTH*ARRAY_SIZE  weight row k; element j in bits [j*WGT_WIDTH +: WGT_WIDTH]
act_valid  input  1  activation vector beat valid
act_ready  output  1  activation beat accepted when valid&ready
act_data_in  input  ACT_WIDTH*ARRAY_SIZE  activation vector; element k in slice k
act_last  input  1  marks final vector of a batch
result_valid  output  1  result vector valid (no backpressure)
result_data_out  output  PE_OUT_WIDTH*ARRAY_SIZE  y_j in slice j
result_last  output  1  result corresponds to the act_last beat
busy  output  1  high in LOAD, STREAM, DRAIN

Behaviour:
- Function: y_j = sum_k a_k * W[k][j], with W[k][j] from row beat k, element j.
  - Products sign- or zero-extended per SIGNED.
  - Sums wrap modulo 2^PE_OUT_WIDTH; no saturation.
- Latency: exactly 2*ARRAY_SIZE cycles from the accept edge of an activation beat to the result_valid cycle.
  - Bubbles (act_valid low) propagate as result_valid low in the same relative slot.
  - Order preserved; one result per accepted beat.
- FSM states: EMPTY, LOAD, READY, STREAM, DRAIN.
  - EMPTY: wgt_ready=1, act_ready=0. Accepted row 0 -> LOAD, row counter=1.
  - LOAD: wgt_ready=1, act_ready=0. Each accept writes row[counter]; after row ARRAY_SIZE-1 -> READY.
  - READY: act_ready=1, wgt_ready=!act_valid (activation has priority).
    - Accepted act beat -> STREAM, or DRAIN if act_last.
    - Accepted weight row -> LOAD and overwrites row 0; previous weights are invalid from then on.
  - STREAM: act_ready=1, wgt_ready=0. Accepted beat with act_last -> DRAIN.
  - DRAIN: both readys 0. Counter runs 2*ARRAY_SIZE cycles, ending on the cycle result_last is asserted; next state READY.
- Weights stay resident across batches until reloaded.
- Skew: element k delayed k cycles entering PE row k. De-skew: column j delayed ARRAY_SIZE-1-j cycles before the output register.
- Reset:
  - EMPTY; all weights, pipeline and skew registers = 0.
  - result_valid=0, result_last=0, result_data_out=0, busy=0, wgt_ready=1, act_ready=0.
  - Reset mid-stream/mid-drain flushes: no result_valid may assert after reset for beats accepted before it.
- act_last in READY with a single beat is legal: DRAIN directly, one result with result_last=1.
- result_data_out holds its last value while result_valid=0. It is don't-care for checking, but must not be X after reset.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum (EMPTY, LOAD, READY, STREAM, DRAIN);
  - localparam LATENCY = 2*ARRAY_SIZE;
  - function clog2 for counter widths.
- One natural sub-module, systolic_pe:
  - weight register with load enable;
  - activation pass-right register;
  - MAC (psum_in + a*w) into a registered psum_out passed down, with a valid bit travelling alongside.
- Skew/de-skew shift registers, the FSM and the last-tag pipeline live in the top level.

Test Plan:
- ARRAY_SIZE=2 SIGNED=0: load rows {1,2},{3,4}; stream a={1,2} then a={3,4} (last) -> results {7,10} then {15,22}. Each arrives exactly 4 cycles after its accept; result_last on the second; back to READY.
- Back-pressure/priority: in READY drive wgt_valid and act_valid together -> only act accepted (wgt_ready=0), weights unchanged, results as above.
- SIGNED=1, ARRAY_SIZE=4: identity W, a={-1,127,-128,5} -> y={-1,127,-128,5} sign-extended to 32 bits. Then W all 8'h80, a all 8'h80 -> each y = 4*16384 = 65536.
- Bubbles: ARRAY_SIZE=4, stream 6 beats with act_valid low on beats 2 and 4 -> result_valid pattern matches the input pattern shifted 8 cycles, values correct.
- Reset mid-stream: assert reset 2 cycles after the third accept -> no result_valid afterwards, state EMPTY, busy=0, wgt_ready=1. A fresh load+stream then gives correct results.
- Reload: after a batch, load new W=2*I -> next batch a={1,2,3,4} gives {2,4,6,8}, proving old weights are fully replaced.
